// File: rtl/prog_mem.sv
// Program memory for a small CPU core: 16 x 8 image written by a byte-serial loader, read
// combinationally by the core. Optional trailing checksum byte when PROG_MEM_CHECKSUM_EN is defined.
module prog_mem #(
  parameter logic [7:0] FILL = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] cpu_addr,
  output logic [7:0] cpu_data,
  output logic       cpu_run,
  input  logic       ld_start,
  input  logic       ld_valid,
  input  logic [7:0] ld_data,
  output logic       ld_ready,
  output logic       ld_busy,
  output logic       ld_error
);

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned LW    = 5;

`ifdef PROG_MEM_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CHECK, S_RUN, S_ERROR} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_RUN, S_ERROR} state_t;
`endif

  state_t        state_q, state_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] len_q, len_d;
  logic          cpu_run_q, cpu_run_d;
  logic          ld_ready_q, ld_ready_d;
  logic          ld_busy_q, ld_busy_d;
  logic          ld_error_q, ld_error_d;
  logic          xfer;
`ifdef PROG_MEM_CHECKSUM_EN
  logic [DW-1:0] sum_q, sum_d;
`endif

  assign xfer = ld_valid && ld_ready_q;

  // Next-state, memory write and registered-output decode
  always_comb begin
    state_d  = state_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    len_d    = len_q;
`ifdef PROG_MEM_CHECKSUM_EN
    sum_d    = sum_q;
`endif
    case (state_q)
      S_IDLE, S_RUN, S_ERROR: begin
        if (ld_start) begin
          state_d  = S_LEN;
          wr_ptr_d = '0;
          for (int i = 0; i < int'(DEPTH); i++) mem_d[i] = FILL;
`ifdef PROG_MEM_CHECKSUM_EN
          sum_d    = '0;
`endif
        end
      end
      S_LEN: begin
        if (xfer) begin
          len_d = LW'(ld_data);
`ifdef PROG_MEM_CHECKSUM_EN
          sum_d = sum_q + ld_data;
`endif
          if ((ld_data != '0) && (ld_data <= DW'(DEPTH))) state_d = S_DATA;
          else                                              state_d = S_ERROR;
        end
      end
      S_DATA: begin
        if (xfer) begin
          mem_d[wr_ptr_q] = ld_data;
          wr_ptr_d        = wr_ptr_q + AW'(1);
`ifdef PROG_MEM_CHECKSUM_EN
          sum_d           = sum_q + ld_data;
          if ((LW'(wr_ptr_q) + LW'(1)) == len_q) state_d = S_CHECK;
`else
          if ((LW'(wr_ptr_q) + LW'(1)) == len_q) state_d = S_RUN;
`endif
        end
      end
`ifdef PROG_MEM_CHECKSUM_EN
      // Image stays in memory on a bad checksum; cpu_run=0 hides it from the core
      S_CHECK: begin
        if (xfer) state_d = ((sum_q + ld_data) == '0) ? S_RUN : S_ERROR;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    cpu_run_d  = (state_d == S_RUN);
    ld_error_d = (state_d == S_ERROR);
`ifdef PROG_MEM_CHECKSUM_EN
    ld_busy_d  = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CHECK);
`else
    ld_busy_d  = (state_d == S_LEN) || (state_d == S_DATA);
`endif
    ld_ready_d = ld_busy_d;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      len_q      <= '0;
      cpu_run_q  <= 1'b0;
      ld_ready_q <= 1'b0;
      ld_busy_q  <= 1'b0;
      ld_error_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= FILL;
`ifdef PROG_MEM_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      len_q      <= len_d;
      cpu_run_q  <= cpu_run_d;
      ld_ready_q <= ld_ready_d;
      ld_busy_q  <= ld_busy_d;
      ld_error_q <= ld_error_d;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= mem_d[i];
`ifdef PROG_MEM_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign cpu_data = cpu_run_q ? mem_q[cpu_addr] : FILL;
  assign cpu_run  = cpu_run_q;
  assign ld_ready = ld_ready_q;
  assign ld_busy  = ld_busy_q;
  assign ld_error = ld_error_q;

endmodule

// File: doc/prog_mem.md
PROG_MEM -- requirements
Module: prog_mem

Interface
REQ-001 Parameter: FILL, 8'h00, value returned for unloaded locations and cleared memory.
REQ-002 clock  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 cpu_addr  input  4  instruction fetch address driven by the CPU core.
REQ-005 cpu_data  output  8  instruction byte; [7:4] opcode, [3:0] imm.
REQ-006 cpu_run  output  1  high = CPU core may execute; wired to the core's active-low reset.
REQ-007 ld_start  input  1  single-cycle request to begin a program load.
REQ-008 ld_valid  input  1  loader byte valid.
REQ-009 ld_data  input  8  loader byte.
REQ-010 ld_ready  output  1  block can accept a loader byte this cycle.
REQ-011 ld_busy  output  1  high while a load is in progress.
REQ-012 ld_error  output  1  sticky error flag for last load.

Function
REQ-013 States SHALL be IDLE, LEN, DATA, CHECK, RUN, ERROR; storage SHALL be 16 x 8-bit registers.
REQ-014 Byte transfer SHALL occur only in a cycle with ld_valid=1 and ld_ready=1; ld_ready SHALL be 1 exactly in LEN, DATA, CHECK.
REQ-015 ld_start in IDLE, RUN or ERROR SHALL move to LEN next cycle, clear all 16 locations to FILL, zero write pointer and running sum, clear ld_error, drop cpu_run.
REQ-016 ld_start in LEN, DATA or CHECK SHALL be ignored.
REQ-017 LEN: accepted byte N SHALL be stored as length; N in 1..16 -> DATA; N=0 or N>16 -> ERROR.
REQ-018 DATA: each accepted byte SHALL write mem[wr_ptr], wr_ptr increments by 1; after N-th byte -> RUN (or CHECK when checksum compiled in).
REQ-019 Locations at index >= N SHALL retain FILL.
REQ-020 cpu_data SHALL equal mem[cpu_addr] combinationally (zero latency) when cpu_run=1, and FILL when cpu_run=0.
REQ-021 cpu_run SHALL be registered: 1 in RUN only, asserting the cycle after the final load byte is accepted.
REQ-022 cpu_addr wrap (15 -> 0) SHALL need no special handling; all 16 locations are readable.
REQ-023 ld_busy SHALL be 1 in LEN, DATA, CHECK; ld_error SHALL be 1 in ERROR only.
REQ-024 ERROR SHALL hold cpu_run=0 until ld_start or reset.

Reset
REQ-025 reset=0 at a rising edge SHALL force IDLE, all memory to FILL, wr_ptr=0, sum=0, cpu_run=0, ld_ready=0, ld_busy=0, ld_error=0, regardless of state, including mid-load.
REQ-026 IDLE SHALL hold cpu_run=0 until a successful load completes.

Configuration
REQ-027 Macro PROG_MEM_CHECKSUM_EN defined: sum SHALL be 8-bit mod-256 of length byte and all payload bytes; after payload, CHECK accepts one byte; (sum + byte) mod 256 = 0 -> RUN, else ERROR with memory contents kept.
REQ-028 PROG_MEM_CHECKSUM_EN undefined: CHECK state and sum register SHALL be absent; DATA goes directly to RUN after N-th byte.

Verification
REQ-029 Reset low 2 cycles mid-DATA -> next cycle IDLE, cpu_run=0, ld_busy=0, cpu_data=8'h00 for every cpu_addr.
REQ-030 Load N=3 bytes 8'h31, 8'h50, 8'hF0 (checksum 8'h8C when enabled) -> cpu_run=1 cycle after last byte; cpu_addr 0/1/2/3 -> 8'h31/8'h50/8'hF0/8'h00.
REQ-031 ld_valid toggled with gaps, ld_start pulsed during DATA -> only handshaken bytes written, ld_start ignored, same final image as REQ-030.
REQ-032 Length byte 8'h00, then separately 8'h11 -> ERROR, ld_error=1, cpu_run=0; ld_start then full 16-byte load clears ld_error and reaches RUN with addr 15 readable.
REQ-033 With PROG_MEM_CHECKSUM_EN: REQ-030 payload with checksum 8'h8D -> ERROR, ld_error=1, cpu_run=0.
REQ-034 In RUN, ld_start -> next cycle cpu_run=0, all locations FILL, ld_ready=1; second load with new image -> RUN serving new bytes.
